// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback unit: load funct3 codes,
// the buffered-result record and the default buffer/starvation sizing.
package wb_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct_e;

  localparam int unsigned DEFAULT_ALU_FIFO_DEPTH = 2;
  localparam int unsigned DEFAULT_STARVE_LIMIT   = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Count-based FIFO holding ALU results until the writeback selector drains them.
// full_o/empty_o come straight from flops so alu_ready has no combinational path.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: merges load responses and buffered ALU results into one
// register-file write per cycle, and tracks pending destinations for decode.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned ALU_FIFO_DEPTH = DEFAULT_ALU_FIFO_DEPTH,
  parameter int unsigned STARVE_LIMIT   = DEFAULT_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic [1:0]  ld_addr_lo,
  input  logic [2:0]  ld_funct3,
  output logic        ld_ready,
  input  logic [4:0]  addr_rd_port1,
  input  logic [4:0]  addr_rd_port2,
  output logic        hazard_1,
  output logic        hazard_2,
  output logic        wr_rd_en,
  output logic [4:0]  addr_wr,
  output logic [31:0] write_port
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t   alu_entry, head;
  logic        fifo_full, fifo_empty;
  logic        alu_fire, ld_fire, pop;
  logic        sel_valid;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   busy_q, busy_d;
  logic          wr_en_q;
  logic [4:0]    addr_wr_q;
  logic [31:0]   wdata_q;

  assign alu_entry = '{rd: alu_rd, data: alu_data};

  wb_fifo #(
    .DEPTH (ALU_FIFO_DEPTH),
    .WIDTH ($bits(wb_entry_t))
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (alu_fire),
    .push_data_i (alu_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // ld_ready is withheld for one cycle once the FIFO has been starved long enough.
  assign ld_ready  = (starve_q != SW'(STARVE_LIMIT));
  assign alu_ready = ~fifo_full;
  assign alu_fire  = alu_valid & alu_ready;
  assign ld_fire   = ld_valid & ld_ready;
  assign pop       = ~ld_fire & ~fifo_empty;

  always_comb begin
    ld_byte = 8'(ld_data >> {ld_addr_lo, 3'b000});
    ld_half = ld_addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
    case (ld_funct3)
      LB:      ld_ext = {{24{ld_byte[7]}}, ld_byte};
      LH:      ld_ext = {{16{ld_half[15]}}, ld_half};
      LBU:     ld_ext = {24'b0, ld_byte};
      LHU:     ld_ext = {16'b0, ld_half};
      default: ld_ext = ld_data;
    endcase
  end

  always_comb begin
    sel_valid = ld_fire | pop;
    sel_rd    = ld_fire ? ld_rd  : head.rd;
    sel_data  = ld_fire ? ld_ext : head.data;
  end

  always_comb begin
    starve_d = starve_q;
    if (pop) starve_d = '0;
    else if (fifo_full && starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
  end

  // Clear before set so a retire and re-issue of the same rd stays pending.
  always_comb begin
    busy_d = busy_q;
    if (sel_valid) busy_d[sel_rd] = 1'b0;
    if (issue_valid) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q  <= '0;
      busy_q    <= '0;
      wr_en_q   <= 1'b0;
      addr_wr_q <= '0;
      wdata_q   <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q   <= busy_d;
      wr_en_q  <= sel_valid && (sel_rd != 5'd0);
      if (sel_valid && sel_rd != 5'd0) begin
        addr_wr_q <= sel_rd;
        wdata_q   <= sel_data;
      end
    end
  end

  assign wr_rd_en   = wr_en_q;
  assign addr_wr    = addr_wr_q;
  assign write_port = wdata_q;
  assign hazard_1   = busy_q[addr_rd_port1];
  assign hazard_2   = busy_q[addr_rd_port2];

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed corner sequences, a load-extraction table
// and a randomized run against a queue-based reference model.
module tb_writeback_unit;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [1:0]  ld_addr_lo;
  logic [2:0]  ld_funct3;
  logic        ld_ready;
  logic [4:0]  addr_rd_port1, addr_rd_port2;
  logic        hazard_1, hazard_2;
  logic        wr_rd_en;
  logic [4:0]  addr_wr;
  logic [31:0] write_port;

  writeback_unit dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .alu_ready     (alu_ready),
    .ld_valid      (ld_valid),
    .ld_rd         (ld_rd),
    .ld_data       (ld_data),
    .ld_addr_lo    (ld_addr_lo),
    .ld_funct3     (ld_funct3),
    .ld_ready      (ld_ready),
    .addr_rd_port1 (addr_rd_port1),
    .addr_rd_port2 (addr_rd_port2),
    .hazard_1      (hazard_1),
    .hazard_2      (hazard_2),
    .wr_rd_en      (wr_rd_en),
    .addr_wr       (addr_wr),
    .write_port    (write_port)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] data;
    logic [31:0] exp;
  } ext_vec_t;

  ext_vec_t vecs[11];

  // Reference model state
  logic [36:0] alu_q[$];
  logic [36:0] exp_q[$];
  int          starve_m;
  bit          busy_m[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0; ld_addr_lo = 0; ld_funct3 = 3'b010;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1; alu_rd = rd; alu_data = d;
  endtask

  task automatic drive_ld(input logic [4:0] rd, input logic [31:0] d,
                          input logic [1:0] lo, input logic [2:0] f3);
    ld_valid = 1; ld_rd = rd; ld_data = d; ld_addr_lo = lo; ld_funct3 = f3;
  endtask

  // Extraction written as plain arithmetic on the byte/half value
  function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [1:0] lo,
                                          input logic [31:0] d);
    longint b, h;
    b = (d >> (8 * lo)) & 32'hFF;
    h = (d >> (16 * lo[1])) & 32'hFFFF;
    case (f3)
      3'b000: begin if (b >= 128) b = b - 256; return 32'(b); end
      3'b001: begin if (h >= 32768) h = h - 65536; return 32'(h); end
      3'b100: return 32'(b);
      3'b101: return 32'(h);
      default: return d;
    endcase
  endfunction

  function automatic logic [4:0] rand_rd();
    int r;
    r = $urandom_range(0, 39);
    return (r > 31) ? 5'd0 : 5'(r);
  endfunction

  task automatic check_write(input string name, input logic [4:0] rd, input logic [31:0] d);
    check({name, ".en"}, wr_rd_en, 1);
    check({name, ".addr"}, addr_wr, rd);
    check({name, ".data"}, write_port, d);
  endtask

  initial begin
    vecs[0]  = '{3'b000, 2'd1, 32'h80FF7F01, 32'h0000007F};
    vecs[1]  = '{3'b000, 2'd3, 32'h80FF7F01, 32'hFFFFFF80};
    vecs[2]  = '{3'b100, 2'd3, 32'h80FF7F01, 32'h00000080};
    vecs[3]  = '{3'b001, 2'd2, 32'h80FF7F01, 32'hFFFF80FF};
    vecs[4]  = '{3'b001, 2'd0, 32'h80FF7F01, 32'h00007F01};
    vecs[5]  = '{3'b101, 2'd2, 32'h80FF7F01, 32'h000080FF};
    vecs[6]  = '{3'b010, 2'd1, 32'h80FF7F01, 32'h80FF7F01};
    vecs[7]  = '{3'b000, 2'd0, 32'h80FF7F01, 32'h00000001};
    vecs[8]  = '{3'b011, 2'd1, 32'h80FF7F01, 32'h80FF7F01};
    vecs[9]  = '{3'b100, 2'd2, 32'h80FF7F01, 32'h000000FF};
    vecs[10] = '{3'b111, 2'd3, 32'h12345678, 32'h12345678};

    rst = 1; idle();
    addr_rd_port1 = 5'd3; addr_rd_port2 = 5'd9;
    step(); step();
    check("rst.wr_rd_en", wr_rd_en, 0);
    check("rst.addr_wr", addr_wr, 0);
    check("rst.write_port", write_port, 0);
    check("rst.alu_ready", alu_ready, 1);
    check("rst.ld_ready", ld_ready, 1);
    check("rst.hazard_1", hazard_1, 0);
    check("rst.hazard_2", hazard_2, 0);
    rst = 0;
    step();

    // Lone ALU result: buffered at the first edge, written at the next
    drive_alu(5'd5, 32'h1234);
    step();
    idle();
    check("alu5.pre", wr_rd_en, 0);
    step();
    check_write("alu5", 5'd5, 32'h00001234);
    step();
    check("alu5.pulse", wr_rd_en, 0);

    // Load beats ALU in the same cycle
    drive_ld(5'd7, 32'hCAFE0007, 2'd0, 3'b010);
    drive_alu(5'd8, 32'hBEEF0008);
    step();
    idle();
    check_write("ldfirst.x7", 5'd7, 32'hCAFE0007);
    step();
    check_write("ldfirst.x8", 5'd8, 32'hBEEF0008);
    step();
    check("ldfirst.pulse", wr_rd_en, 0);

    // Load extraction table
    for (int i = 0; i < 11; i++) begin
      drive_ld(5'(i + 1), vecs[i].data, vecs[i].lo, vecs[i].f3);
      step();
      check_write($sformatf("ext%0d", i), 5'(i + 1), vecs[i].exp);
    end
    idle();
    step();

    // Starvation: continuous loads with the FIFO full
    for (int c = 0; c < 9; c++) begin
      drive_ld(5'(16 + c), 32'hA0000000 + c, 2'd0, 3'b010);
      if (c < 2) drive_alu(5'(10 + c), 32'hB0 + c);
      else alu_valid = 0;
      #1;
      check($sformatf("starve.ld_ready%0d", c), ld_ready, (c == 6) ? 0 : 1);
      step();
      if (c == 6) check_write("starve.head", 5'd10, 32'hB0);
      else check_write($sformatf("starve.ld%0d", c), 5'(16 + c), 32'hA0000000 + c);
    end
    idle();
    step();
    check_write("starve.tail", 5'd11, 32'hB1);
    step();

    // Hazard tracking on x3
    addr_rd_port1 = 5'd3;
    issue_valid = 1; issue_rd = 5'd3;
    #1;
    check("haz.before_set", hazard_1, 0);
    step();
    idle();
    check("haz.set", hazard_1, 1);
    drive_alu(5'd3, 32'h33);
    step();
    idle();
    check("haz.buffered", hazard_1, 1);
    check("haz.no_write", wr_rd_en, 0);
    step();
    check_write("haz.retire", 5'd3, 32'h33);
    check("haz.cleared", hazard_1, 0);
    issue_valid = 1; issue_rd = 5'd3;
    step();
    idle();
    drive_alu(5'd3, 32'h44);
    step();
    idle();
    issue_valid = 1; issue_rd = 5'd3;
    step();
    idle();
    check_write("haz.reissue", 5'd3, 32'h44);
    check("haz.reissue_kept", hazard_1, 1);

    // x0 destination: consumed without a write, never busy
    addr_rd_port2 = 5'd0;
    issue_valid = 1; issue_rd = 5'd0;
    drive_alu(5'd0, 32'h55);
    step();
    idle();
    check("x0.hazard", hazard_2, 0);
    step();
    check("x0.no_write", wr_rd_en, 0);
    check("x0.fifo_drained", alu_ready, 1);
    step();
    check("x0.no_write2", wr_rd_en, 0);

    // Reset with two ALU results buffered behind loads
    addr_rd_port2 = 5'd9;
    drive_ld(5'd20, 32'h20, 2'd0, 3'b010);
    drive_alu(5'd21, 32'h21);
    issue_valid = 1; issue_rd = 5'd9;
    step();
    drive_ld(5'd22, 32'h22, 2'd0, 3'b010);
    drive_alu(5'd23, 32'h23);
    issue_valid = 0;
    step();
    check("midrst.full", alu_ready, 0);
    check("midrst.busy9", hazard_2, 1);
    idle();
    rst = 1;
    #1;
    check("midrst.wr_rd_en", wr_rd_en, 0);
    check("midrst.alu_ready", alu_ready, 1);
    check("midrst.ld_ready", ld_ready, 1);
    check("midrst.hazard_1", hazard_1, 0);
    check("midrst.hazard_2", hazard_2, 0);
    step();
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("midrst.nowrite%0d", c), wr_rd_en, 0);
      check($sformatf("midrst.alu_ready%0d", c), alu_ready, 1);
    end

    // Randomized run against the reference model (starts from clean reset state)
    alu_q.delete();
    starve_m = 0;
    foreach (busy_m[i]) busy_m[i] = 0;
    for (int c = 0; c < 500; c++) begin
      bit          exp_alu_rdy, exp_ld_rdy, was_full, sel, exp_en;
      logic [36:0] ent;
      alu_valid = 1'($urandom_range(0, 1));
      alu_rd = rand_rd(); alu_data = $urandom;
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_rd = rand_rd(); ld_data = $urandom;
      ld_addr_lo = 2'($urandom_range(0, 3)); ld_funct3 = 3'($urandom_range(0, 7));
      issue_valid = 1'($urandom_range(0, 1)); issue_rd = rand_rd();
      addr_rd_port1 = 5'($urandom_range(0, 31)); addr_rd_port2 = 5'($urandom_range(0, 31));
      #1;
      exp_alu_rdy = (alu_q.size() < DEPTH);
      exp_ld_rdy  = (starve_m != LIMIT);
      check("rnd.alu_ready", alu_ready, exp_alu_rdy);
      check("rnd.ld_ready", ld_ready, exp_ld_rdy);
      check("rnd.hazard_1", hazard_1, busy_m[addr_rd_port1]);
      check("rnd.hazard_2", hazard_2, busy_m[addr_rd_port2]);

      was_full = (alu_q.size() == DEPTH);
      sel = 0; ent = '0;
      if (ld_valid && exp_ld_rdy) begin
        sel = 1; ent = {ld_rd, ref_ext(ld_funct3, ld_addr_lo, ld_data)};
      end else if (alu_q.size() > 0) begin
        sel = 1; ent = alu_q.pop_front();
        starve_m = 0;
      end
      if (!(sel && !(ld_valid && exp_ld_rdy)) && was_full) starve_m++;
      if (alu_valid && exp_alu_rdy) alu_q.push_back({alu_rd, alu_data});
      if (sel) busy_m[ent[36:32]] = 0;
      if (issue_valid && issue_rd != 0) busy_m[issue_rd] = 1;
      exp_en = sel && (ent[36:32] != 0);
      if (exp_en) exp_q.push_back(ent);

      step();
      check("rnd.wr_rd_en", wr_rd_en, exp_en);
      if (exp_en) begin
        ent = exp_q.pop_front();
        check("rnd.addr_wr", addr_wr, ent[36:32]);
        check("rnd.write_port", write_port, ent[31:0]);
      end
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
